// File: rtl/block_loader_if.sv
// Handshake and block-write bundle between the stream/command source and block_loader.
// The master side issues commands and stream words; the slave side is the loader itself.
interface block_loader_if #(
  parameter int BITWIDTH  = 8,
  parameter int MESHUNITS = 2,
  parameter int TILEUNITS = 2
);
  localparam int BLOCK_SIZE = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic        [BITWIDTH-1:0] cmd_base_addr;
  logic        [BITWIDTH-1:0] cmd_num_blocks;
  logic                       in_valid;
  logic                       in_ready;
  logic signed [BITWIDTH-1:0] in_data;
  logic                       loader_write_valid;
  logic        [BITWIDTH-1:0] loader_write_addr;
  logic signed [BITWIDTH-1:0] loader_write_data [BLOCK_SIZE-1:0];
  logic                       busy;
  logic                       done;

  modport master (
    output cmd_valid, cmd_base_addr, cmd_num_blocks, in_valid, in_data,
    input  cmd_ready, in_ready, loader_write_valid, loader_write_addr,
           loader_write_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_base_addr, cmd_num_blocks, in_valid, in_data,
    output cmd_ready, in_ready, loader_write_valid, loader_write_addr,
           loader_write_data, busy, done
  );
endinterface

// File: rtl/block_loader.sv
// Assembles a word-serial signed stream into BLOCK_SIZE-word blocks and issues one
// single-cycle block write per block at consecutive block-aligned addresses.
module block_loader #(
  parameter int ADDRSIZE  = 256,
  parameter int BITWIDTH  = 8,
  parameter int MESHUNITS = 2,
  parameter int TILEUNITS = 2
) (
  input logic          clock,
  input logic          reset,
  block_loader_if.slave bus
);
  localparam int BLOCK_SIZE = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
  localparam int IDX_W      = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [BITWIDTH-1:0] ADDR_MASK  = BITWIDTH'(ADDRSIZE - 1);
  localparam logic [BITWIDTH-1:0] ALIGN_MASK = ~(BITWIDTH'(BLOCK_SIZE - 1));
  localparam logic [BITWIDTH-1:0] BLK_STEP   = BITWIDTH'(BLOCK_SIZE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                     state;
  logic signed [BITWIDTH-1:0] buffer [BLOCK_SIZE-1:0];
  logic        [IDX_W-1:0]    word_idx;
  logic        [BITWIDTH-1:0] cur_addr;
  logic        [BITWIDTH-1:0] remaining;

  function automatic logic [BITWIDTH-1:0] align_addr(input logic [BITWIDTH-1:0] addr);
    return addr & ALIGN_MASK & ADDR_MASK;
  endfunction

  // Control FSM; handshake flags are registered alongside each state change.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      word_idx  <= {IDX_W{1'b0}};
      cur_addr  <= {BITWIDTH{1'b0}};
      remaining <= {BITWIDTH{1'b0}};
      for (int i = 0; i < BLOCK_SIZE; i++) begin
        buffer[i]                <= {BITWIDTH{1'b0}};
        bus.loader_write_data[i] <= {BITWIDTH{1'b0}};
      end
      bus.loader_write_valid <= 1'b0;
      bus.loader_write_addr  <= {BITWIDTH{1'b0}};
      bus.done               <= 1'b0;
      bus.busy               <= 1'b0;
      bus.in_ready           <= 1'b0;
      bus.cmd_ready          <= 1'b1;
    end else begin
      bus.loader_write_valid <= 1'b0;
      bus.done               <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            cur_addr      <= align_addr(bus.cmd_base_addr);
            remaining     <= bus.cmd_num_blocks;
            word_idx      <= {IDX_W{1'b0}};
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            if (bus.cmd_num_blocks == {BITWIDTH{1'b0}}) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state        <= FILL;
              bus.in_ready <= 1'b1;
            end
          end
        end
        FILL: begin
          if (bus.in_valid && bus.in_ready) begin
            buffer[word_idx] <= bus.in_data;
            if (word_idx == LAST_IDX) begin
              // The final beat bypasses the buffer so the write can go out next cycle.
              state                  <= WRITE;
              bus.in_ready           <= 1'b0;
              bus.loader_write_valid <= 1'b1;
              bus.loader_write_addr  <= cur_addr;
              for (int i = 0; i < BLOCK_SIZE; i++) begin
                bus.loader_write_data[i] <= (i == BLOCK_SIZE - 1) ? bus.in_data : buffer[i];
              end
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          cur_addr  <= (cur_addr + BLK_STEP) & ADDR_MASK;
          remaining <= remaining - BITWIDTH'(1);
          if (remaining == BITWIDTH'(1)) begin
            state    <= DONE;
            bus.done <= 1'b1;
          end else begin
            state        <= FILL;
            word_idx     <= {IDX_W{1'b0}};
            bus.in_ready <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.busy      <= 1'b0;
          bus.in_ready  <= 1'b0;
          bus.cmd_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_block_loader.sv
// Directed bench for block_loader: stimulus pushes expected writes/done pulses into a
// queue, and a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_block_loader;
  localparam int BW = 8;
  localparam int BS = 16;

  typedef struct packed {
    logic           is_done;
    logic [31:0]    cyc;
    logic [BW-1:0]  addr;
    logic [BS*BW-1:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  exp_t exp_q[$];

  always #5 clock = ~clock;

  block_loader_if #(.BITWIDTH(BW), .MESHUNITS(2), .TILEUNITS(2)) bus ();

  block_loader #(.ADDRSIZE(256), .BITWIDTH(BW), .MESHUNITS(2), .TILEUNITS(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: invariants every cycle, queued events on every strobe.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("busy_vs_cmd_ready", {31'd0, bus.busy}, {31'd0, ~bus.cmd_ready});
      chk("no_dual_ready", {31'd0, bus.in_ready & bus.cmd_ready}, 32'd0);
      if (bus.loader_write_valid === 1'b1) chk("in_ready_in_write", {31'd0, bus.in_ready}, 32'd0);
      if (bus.loader_write_valid === 1'b1 || bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", {30'd0, bus.loader_write_valid, bus.done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("event_kind", {30'd0, bus.loader_write_valid, bus.done}, {30'd0, ~e.is_done, e.is_done});
          chk("event_cycle", 32'(cyc), e.cyc);
          if (!e.is_done) begin
            chk("write_addr", {24'd0, bus.loader_write_addr}, {24'd0, e.addr});
            for (int i = 0; i < BS; i++) begin
              chk($sformatf("write_data[%0d]", i), {24'd0, bus.loader_write_data[i]},
                  {24'd0, e.data[i*BW +: BW]});
            end
          end
        end
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_write_valid", {31'd0, bus.loader_write_valid}, 32'd0);
    chk("rst_write_addr", {24'd0, bus.loader_write_addr}, 32'd0);
    for (int i = 0; i < BS; i++) chk("rst_write_data", {24'd0, bus.loader_write_data[i]}, 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send_cmd(input logic [BW-1:0] base, input logic [BW-1:0] num);
    bit ok = 1'b0;
    bus.cmd_valid      = 1'b1;
    bus.cmd_base_addr  = base;
    bus.cmd_num_blocks = num;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (bus.cmd_ready) begin
        ok = 1'b1;
        if (num == 8'd0) exp_q.push_back('{1'b1, 32'(cyc + 1), 8'd0, '0});
      end
      @(negedge clock);
    end
    bus.cmd_valid = 1'b0;
    if (!ok) chk("cmd_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_beat(input logic [BW-1:0] v, input bit push_wr, input logic [BW-1:0] addr,
                           input logic [BS*BW-1:0] data, input bit push_done);
    bit ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        if (push_wr)   exp_q.push_back('{1'b0, 32'(cyc + 1), addr, data});
        if (push_done) exp_q.push_back('{1'b1, 32'(cyc + 2), 8'd0, '0});
      end
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  // Streams words start, start+1, ... ; expected data is word i = start+i.
  task automatic load_block(input logic [BW-1:0] addr, input logic [BW-1:0] start,
                            input bit gap, input bit last);
    logic [BS*BW-1:0] d;
    for (int i = 0; i < BS; i++) d[i*BW +: BW] = start + 8'(i);
    for (int i = 0; i < BS; i++) begin
      send_beat(start + 8'(i), i == BS - 1, addr, d, last && (i == BS - 1));
      if (gap && i < BS - 1) @(negedge clock);
    end
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (bus.cmd_ready === 1'b1) ok = 1'b1;
      else @(negedge clock);
    end
    if (!ok) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid      = 1'b0;
    bus.cmd_base_addr  = 8'd0;
    bus.cmd_num_blocks = 8'd0;
    bus.in_valid       = 1'b0;
    bus.in_data        = 8'sd0;
    repeat (3) @(negedge clock);
    check_reset_state();
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);

    // Single block, data 1..16 at 0x00.
    send_cmd(8'h00, 8'd1);
    load_block(8'h00, 8'd1, 1'b0, 1'b1);
    wait_idle();

    // Base 0x25 aligns to 0x20; two blocks, second word-0 beat held across the write cycle.
    send_cmd(8'h25, 8'd2);
    load_block(8'h20, 8'd0, 1'b0, 1'b0);
    load_block(8'h30, 8'd16, 1'b0, 1'b1);
    wait_idle();

    // Address wrap 0xF0 -> 0x00.
    send_cmd(8'hF0, 8'd2);
    load_block(8'hF0, 8'd0, 1'b0, 1'b0);
    load_block(8'h00, 8'd16, 1'b0, 1'b1);
    wait_idle();

    // Gapped stream with negative words; a beat held after the only block is never taken.
    send_cmd(8'h33, 8'd1);
    load_block(8'h30, 8'hF8, 1'b1, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'sh55;
    for (int t = 0; t < 6; t++) begin
      chk("held_beat_not_taken", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    wait_idle();

    // Two gapped blocks: word 0 of the second block is presented during the write cycle.
    send_cmd(8'h50, 8'd2);
    load_block(8'h50, 8'h80, 1'b1, 1'b0);
    load_block(8'h60, 8'h90, 1'b1, 1'b1);
    wait_idle();

    // Command while busy is ignored; then a zero-block command.
    send_cmd(8'h10, 8'd1);
    begin
      logic [BS*BW-1:0] d;
      for (int i = 0; i < BS; i++) d[i*BW +: BW] = 8'h20 + 8'(i);
      for (int i = 0; i < BS; i++) begin
        if (i == 3) begin
          bus.cmd_valid      = 1'b1;
          bus.cmd_base_addr  = 8'h70;
          bus.cmd_num_blocks = 8'd5;
        end
        send_beat(8'h20 + 8'(i), i == BS - 1, 8'h10, d, i == BS - 1);
      end
      bus.cmd_valid = 1'b0;
    end
    wait_idle();
    send_cmd(8'h99, 8'd0);
    wait_idle();

    // Reset mid-fill: partial block dropped, then a fresh load to 0x40.
    send_cmd(8'h80, 8'd1);
    for (int i = 0; i < 7; i++) send_beat(8'(i), 1'b0, 8'd0, '0, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_state();
    reset = 1'b1;
    @(negedge clock);
    send_cmd(8'h40, 8'd1);
    load_block(8'h40, 8'd100, 1'b0, 1'b1);
    wait_idle();

    repeat (10) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/block_loader.md
Name: block_loader

Overview:
- Upstream feeder for the block memory's loader write port.
- Accepts a word-serial signed data stream via a valid/ready handshake and assembles it into full blocks of BLOCK_SIZE words.
- Issues one single-cycle block write per assembled block at consecutive block-aligned addresses.
- Driven by a one-shot command carrying the base address and block count; reports completion with a done pulse.

Parameters:
- ADDRSIZE, 256, block memory depth in words; power of two, at least BLOCK_SIZE.
- BITWIDTH, 8, data word width and address width.
- MESHUNITS, 2, mesh dimension.
- TILEUNITS, 2, tile dimension.
- BLOCK_SIZE (localparam), MESHUNITS*MESHUNITS*TILEUNITS*TILEUNITS (16 by default), words per block.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_base_addr  in  BITWIDTH  destination base address.
- cmd_num_blocks  in  BITWIDTH  blocks to load; 0 is legal.
- in_valid  in  1  stream word valid.
- in_ready  out  1  stream word accepted when in_valid and in_ready are both high.
- in_data  in  BITWIDTH signed  stream word.
- loader_write_valid  out  1  one-cycle block write strobe.
- loader_write_addr  out  BITWIDTH  block-aligned destination address.
- loader_write_data  out  BITWIDTH signed x [BLOCK_SIZE-1:0]  block contents; word i goes to addr+i.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs and state are registered.
- Reset (reset==0 at a rising edge):
  - state=IDLE; buffer, word_idx, cur_addr and remaining all cleared.
  - Outputs: loader_write_valid=0, loader_write_addr=0, loader_write_data all 0, done=0, busy=0, in_ready=0, cmd_ready=1.
- Reset mid-operation: the partial block is discarded, no write is issued, and done does not pulse.

State IDLE:
- cmd_ready=1, in_ready=0.
- On cmd_valid & cmd_ready:
  - Latch cur_addr = cmd_base_addr with its low log2(BLOCK_SIZE) bits cleared, masked with (ADDRSIZE-1).
  - Latch remaining = cmd_num_blocks.
  - If cmd_num_blocks==0, go to DONE; otherwise go to FILL with word_idx=0.

State FILL:
- in_ready=1.
- Each accepted beat writes buffer[word_idx] = in_data, then word_idx increments.
- in_valid low: everything holds; no timeout.
- The beat that fills word_idx = BLOCK_SIZE-1 moves the state to WRITE.

State WRITE (exactly one cycle):
- loader_write_valid=1, loader_write_addr=cur_addr, loader_write_data=buffer.
- in_ready=0; a beat presented this cycle is not consumed.
- Next cycle:
  - cur_addr = (cur_addr + BLOCK_SIZE) & (ADDRSIZE-1), so addresses wrap modulo ADDRSIZE.
  - remaining decrements.
  - If remaining is now 0, go to DONE; otherwise go to FILL with word_idx=0.

State DONE (exactly one cycle):
- done=1, then return to IDLE.

Timing and output rules:
- Latency: last beat of a block accepted in cycle N gives loader_write_valid in cycle N+1; done follows the final write at N+2.
- Minimum spacing between writes is BLOCK_SIZE+1 cycles.
- loader_write_addr and loader_write_data hold their last values outside WRITE; they are only meaningful while loader_write_valid=1.
- Commands presented while busy are ignored (cmd_ready=0) and never queued.
- No simultaneous command and stream acceptance: in_ready and cmd_ready are never both high.

Test Plan:
- cmd base=0x00, num=1; stream values 1..16 on consecutive cycles -> single write at addr 0x00, data[i]=i+1, valid one cycle after beat 16, done the following cycle, busy low after that.
- cmd base=0x25, num=2; stream 0..31 -> writes at 0x20 (data 0..15) then 0x30 (data 16..31); in_ready low during the first write cycle; exactly two write strobes.
- cmd base=0xF0, num=2; stream 0..31 -> writes at 0xF0 then 0x00 (address wrap); second block data 16..31.
- num=1 with in_valid toggling every other cycle and a beat held during the WRITE cycle -> same data as the gap-free case; held beat accepted as word 0 of the next block only when a next block exists.
- cmd num=0 -> done asserted one cycle after the command is accepted, loader_write_valid never asserted; a second cmd_valid issued while busy from another command is ignored.
- num=1, reset driven low after 7 accepted beats -> no write, done never pulses, all outputs at reset values; a new cmd with base=0x40 then loads correctly to 0x40.
